// File: rtl/people_counter_pkg.sv
// Shared FSM encoding and sizing defaults for the people counter and its sensor channels.
// Build option: SENSOR_DEBOUNCE_EN selects the multi-cycle debounce in sensor_debounce.
package people_counter_pkg;

    typedef enum logic [1:0] {
        CLEAR     = 2'd0,
        ARMING    = 2'd1,
        BLOCKED   = 2'd2,
        RELEASING = 2'd3
    } deb_state_t;

    localparam int PCOUNT_W       = 3;
    localparam int MAX_COUNT_DEF  = 7;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int DEB_CNT_W      = 4;

endpackage

// File: rtl/people_counter_sensor_debounce.sv
// One beam channel: 2-flop sync, CLEAR/ARMING/BLOCKED/RELEASING FSM, one-cycle event pulse.
// Latency: pulse 2+DEB_CYCLES cycles after first raw sample (3 when SENSOR_DEBOUNCE_EN undefined).
// No backpressure: the pulse is a fire-and-forget strobe.
module sensor_debounce
    import people_counter_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic event_pulse
);

    logic       sync1;
    logic       s;
    logic       deb_done;
    logic       pulse_nxt;
    deb_state_t state;
    deb_state_t state_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

`ifdef SENSOR_DEBOUNCE_EN
    logic [DEB_CNT_W-1:0] cnt;
    logic [DEB_CNT_W-1:0] cnt_nxt;

    assign deb_done = (cnt == DEB_CNT_W'(DEB_CYCLES - 1));

    // Counts consecutive qualifying samples; any break or state change restarts it.
    always_comb begin
        cnt_nxt = '0;
        if (((state == ARMING) && s) || ((state == RELEASING) && !s)) begin
            cnt_nxt = deb_done ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    // DEB_CYCLES is never 0, so a single qualifying sample completes the debounce.
    assign deb_done = (DEB_CYCLES != 0);
`endif

    always_comb begin
        state_nxt = state;
        pulse_nxt = 1'b0;
        case (state)
            CLEAR: begin
                if (s) state_nxt = ARMING;
            end
            ARMING: begin
                if (!s) begin
                    state_nxt = CLEAR;
                end else if (deb_done) begin
                    state_nxt = BLOCKED;
                    pulse_nxt = 1'b1;
                end
            end
            BLOCKED: begin
                if (!s) state_nxt = RELEASING;
            end
            RELEASING: begin
                if (s) begin
                    state_nxt = BLOCKED;
                end else if (deb_done) begin
                    state_nxt = CLEAR;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= CLEAR;
            event_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            event_pulse <= pulse_nxt;
        end
    end

endmodule

// File: rtl/people_counter.sv
// Occupancy counter: debounced entry/exit channels feeding a saturating pcount register.
// Latency: pcount moves one cycle after its pulse; debounce depth set by SENSOR_DEBOUNCE_EN.
// No backpressure: simultaneous entry/exit pulses cancel.
module people_counter
    import people_counter_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int MAX_COUNT  = MAX_COUNT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                entry_sensor,
    input  logic                exit_sensor,
    output logic                up_count,
    output logic                down_count,
    output logic [PCOUNT_W-1:0] pcount
);

    localparam logic [PCOUNT_W-1:0] MAX_PC = PCOUNT_W'(MAX_COUNT);

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_entry (
        .clk         (clk),
        .reset       (reset),
        .raw         (entry_sensor),
        .event_pulse (up_count)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exit (
        .clk         (clk),
        .reset       (reset),
        .raw         (exit_sensor),
        .event_pulse (down_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcount <= '0;
        end else if (up_count && !down_count && (pcount < MAX_PC)) begin
            pcount <= pcount + 1'b1;
        end else if (down_count && !up_count && (pcount != '0)) begin
            pcount <= pcount - 1'b1;
        end
    end

endmodule

// File: tb/tb_people_counter.sv
// Directed bench for people_counter; expectations follow the SENSOR_DEBOUNCE_EN build choice.
module tb_people_counter;

`ifdef SENSOR_DEBOUNCE_EN
    localparam int DEB_EFF = 4;
`else
    localparam int DEB_EFF = 1;
`endif
    localparam int LAT = 2 + DEB_EFF;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       entry_sensor = 1'b0;
    logic       exit_sensor = 1'b0;
    logic       up_count;
    logic       down_count;
    logic [2:0] pcount;

    int checks = 0;
    int passes = 0;

    int         up_n, dn_n, up_first, dn_first;
    logic [2:0] pc_at_up, pc_at_dn;

    people_counter dut (
        .clk          (clk),
        .reset        (reset),
        .entry_sensor (entry_sensor),
        .exit_sensor  (exit_sensor),
        .up_count     (up_count),
        .down_count   (down_count),
        .pcount       (pcount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advances n cycles, recording pulse counts, first pulse index and pcount seen with it.
    task automatic run(input int n);
        up_n = 0; dn_n = 0; up_first = -1; dn_first = -1;
        pc_at_up = 3'bx; pc_at_dn = 3'bx;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (up_count === 1'b1) begin
                if (up_n == 0) begin up_first = i; pc_at_up = pcount; end
                up_n++;
            end
            if (down_count === 1'b1) begin
                if (dn_n == 0) begin dn_first = i; pc_at_dn = pcount; end
                dn_n++;
            end
        end
    endtask

    task automatic do_reset();
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic one_entry();
        entry_sensor = 1'b1;
        run(LAT + 3);
        entry_sensor = 1'b0;
        run(LAT + 5);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        run(6);
        checks++; if (up_n !== 0) $display("FAIL reset_up: got %0d pulses, need 0", up_n); else passes++;
        checks++; if (dn_n !== 0) $display("FAIL reset_down: got %0d pulses, need 0", dn_n); else passes++;
        checks++; if (pcount !== 3'd0) $display("FAIL reset_pcount: got %0d, need 0", pcount); else passes++;
        do_reset();
    endtask

    task automatic test_entry();
        do_reset();
        entry_sensor = 1'b1;
        run(10);
        checks++; if (up_n !== 1) $display("FAIL entry_count: got %0d, need 1", up_n); else passes++;
        checks++; if (up_first !== LAT + 1) $display("FAIL entry_latency: got %0d, need %0d", up_first, LAT + 1); else passes++;
        checks++; if (pc_at_up !== 3'd0) $display("FAIL entry_pre_pcount: got %0d, need 0", pc_at_up); else passes++;
        checks++; if (dn_n !== 0) $display("FAIL entry_no_down: got %0d, need 0", dn_n); else passes++;
        checks++; if (pcount !== 3'd1) $display("FAIL entry_pcount: got %0d, need 1", pcount); else passes++;
        entry_sensor = 1'b0;
        run(12);
        checks++; if (up_n !== 0) $display("FAIL entry_release: got %0d pulses, need 0", up_n); else passes++;
    endtask

    task automatic test_glitch();
        int         exp_n;
        logic [2:0] exp_pc;
`ifdef SENSOR_DEBOUNCE_EN
        exp_n = 0; exp_pc = 3'd0;
`else
        exp_n = 1; exp_pc = 3'd1;
`endif
        do_reset();
        entry_sensor = 1'b1;
        tick(); tick(); tick();
        entry_sensor = 1'b0;
        run(12);
        checks++; if (up_n !== exp_n) $display("FAIL glitch_pulses: got %0d, need %0d", up_n, exp_n); else passes++;
        checks++; if (pcount !== exp_pc) $display("FAIL glitch_pcount: got %0d, need %0d", pcount, exp_pc); else passes++;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            entry_sensor = 1'b1;
            run(LAT + 3);
            checks++; if (up_n !== 1) $display("FAIL sat_pulse_%0d: got %0d, need 1", k, up_n); else passes++;
            checks++;
            if (pc_at_up !== 3'((k < 7) ? k : 7))
                $display("FAIL sat_pre_%0d: got %0d, need %0d", k, pc_at_up, (k < 7) ? k : 7);
            else passes++;
            entry_sensor = 1'b0;
            run(LAT + 5);
        end
        checks++; if (pcount !== 3'd7) $display("FAIL sat_final: got %0d, need 7", pcount); else passes++;
    endtask

    task automatic test_exit_at_zero();
        do_reset();
        exit_sensor = 1'b1;
        run(LAT + 3);
        checks++; if (dn_n !== 1) $display("FAIL exit0_pulse: got %0d, need 1", dn_n); else passes++;
        checks++; if (dn_first !== LAT + 1) $display("FAIL exit0_latency: got %0d, need %0d", dn_first, LAT + 1); else passes++;
        checks++; if (pc_at_dn !== 3'd0) $display("FAIL exit0_pre: got %0d, need 0", pc_at_dn); else passes++;
        checks++; if (pcount !== 3'd0) $display("FAIL exit0_pcount: got %0d, need 0", pcount); else passes++;
        exit_sensor = 1'b0;
        run(LAT + 5);
    endtask

    task automatic test_back_to_back();
        do_reset();
        entry_sensor = 1'b1; exit_sensor = 1'b1;
        run(LAT + 3);
        checks++; if (up_n !== 1 || dn_n !== 1) $display("FAIL both0_pulses: got up %0d down %0d, need 1 1", up_n, dn_n); else passes++;
        checks++; if (pcount !== 3'd0) $display("FAIL both0_pcount: got %0d, need 0", pcount); else passes++;
        entry_sensor = 1'b0; exit_sensor = 1'b0;
        run(LAT + 5);
        for (int k = 0; k < 3; k++) one_entry();
        checks++; if (pcount !== 3'd3) $display("FAIL both3_setup: got %0d, need 3", pcount); else passes++;
        entry_sensor = 1'b1; exit_sensor = 1'b1;
        run(LAT + 3);
        checks++; if (up_n !== 1 || dn_n !== 1) $display("FAIL both3_pulses: got up %0d down %0d, need 1 1", up_n, dn_n); else passes++;
        checks++; if (up_first !== dn_first) $display("FAIL both3_aligned: got up %0d down %0d", up_first, dn_first); else passes++;
        checks++; if (pcount !== 3'd3) $display("FAIL both3_pcount: got %0d, need 3", pcount); else passes++;
        entry_sensor = 1'b0; exit_sensor = 1'b0;
        run(LAT + 5);
    endtask

    task automatic test_reset_mid_arming();
        do_reset();
        one_entry();
        entry_sensor = 1'b1;
        run(LAT);
        checks++; if (up_n !== 0) $display("FAIL midrst_early: got %0d pulses, need 0", up_n); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (pcount !== 3'd0) $display("FAIL midrst_pcount: got %0d, need 0", pcount); else passes++;
        checks++; if (up_count !== 1'b0) $display("FAIL midrst_up: got %0b, need 0", up_count); else passes++;
        tick(); tick();
        reset = 1'b1;
        run(LAT + 3);
        checks++; if (up_n !== 1) $display("FAIL midrst_count: got %0d, need 1", up_n); else passes++;
        checks++; if (up_first !== LAT + 1) $display("FAIL midrst_latency: got %0d, need %0d", up_first, LAT + 1); else passes++;
        checks++; if (pcount !== 3'd1) $display("FAIL midrst_after: got %0d, need 1", pcount); else passes++;
        // Reset landing in the pulse cycle must drop the pulse immediately.
        entry_sensor = 1'b0;
        run(LAT + 5);
        entry_sensor = 1'b1;
        run(LAT + 1);
        reset = 1'b0;
        #1;
        checks++; if (up_count !== 1'b0) $display("FAIL pulse_drop: got %0b, need 0", up_count); else passes++;
        entry_sensor = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_entry();
        test_glitch();
        test_saturate();
        test_exit_at_zero();
        test_back_to_back();
        test_reset_mid_arming();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
